// File: rtl/adau1761_i2s_port.sv
// ADAU1761 I2S slave data port.
// The codec is the I2S master and drives BCLK/LRCLK. Both are oversampled in the clk
// domain. ADC words are deserialised into left/right holding registers and published
// once per frame. DAC words are latched at the start of each frame and serialised MSB
// first on detected BCLK falls.
module adau1761_i2s_port #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int CNT_WIDTH    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    ac_bclk,
    input  logic                    ac_lrclk,
    input  logic                    ac_adc_sdata,
    output logic                    ac_dac_sdata,
    output logic [SAMPLE_WIDTH-1:0] adc_left,
    output logic [SAMPLE_WIDTH-1:0] adc_right,
    output logic                    adc_valid,
    input  logic [SAMPLE_WIDTH-1:0] dac_left,
    input  logic [SAMPLE_WIDTH-1:0] dac_right,
    output logic                    dac_ready,
    output logic                    frame_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_SW  = CNT_WIDTH'(SAMPLE_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [SAMPLE_WIDTH-1:0] WORD_ZERO = {SAMPLE_WIDTH{1'b0}};

    // Synchroniser stages; index 1 is the synchronised value.
    logic [1:0]              bclk_sync_r;
    logic [1:0]              lrclk_sync_r;
    logic [1:0]              sdata_sync_r;
    logic                    bclk_hist_r;

    // Channel tracking
    logic                    lr_prev_r;
    logic [CNT_WIDTH-1:0]    bit_cnt_r;
    logic                    locked_r;
    logic                    left_ok_r;
    logic                    adc_pend_r;

    // ADC datapath
    logic [SAMPLE_WIDTH-1:0] adc_sr_r;
    logic [SAMPLE_WIDTH-1:0] adc_hold_l_r;
    logic [SAMPLE_WIDTH-1:0] adc_hold_r_r;

    // DAC datapath
    logic [SAMPLE_WIDTH-1:0] dac_hold_r_r;
    logic [SAMPLE_WIDTH-1:0] dac_sr_r;

    // Decoded events
    logic                    bclk_rise_s;
    logic                    bclk_fall_s;
    logic                    lr_change_s;
    logic                    left_start_s;
    logic                    right_start_s;
    logic [CNT_WIDTH-1:0]    cnt_inc_s;
    logic                    shift_s;
    logic                    word_done_s;
    logic [SAMPLE_WIDTH-1:0] word_s;
    logic                    short_s;
    logic                    lock_next_s;
    logic                    active_s;

    // Bring the codec pins into the clk domain and keep one BCLK history bit for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync_r  <= 2'b00;
            lrclk_sync_r <= 2'b00;
            sdata_sync_r <= 2'b00;
            bclk_hist_r  <= 1'b0;
        end else begin
            bclk_sync_r  <= {bclk_sync_r[0], ac_bclk};
            lrclk_sync_r <= {lrclk_sync_r[0], ac_lrclk};
            sdata_sync_r <= {sdata_sync_r[0], ac_adc_sdata};
            bclk_hist_r  <= bclk_sync_r[1];
        end
    end

    // Decode BCLK edges, channel boundaries, bit position and lock qualification.
    always_comb begin
        bclk_rise_s   = bclk_sync_r[1] & ~bclk_hist_r;
        bclk_fall_s   = ~bclk_sync_r[1] & bclk_hist_r;
        lr_change_s   = bclk_rise_s & (lrclk_sync_r[1] != lr_prev_r);
        left_start_s  = lr_change_s & ~lrclk_sync_r[1];
        right_start_s = lr_change_s & lrclk_sync_r[1];
        if (bit_cnt_r != CNT_MAX) begin
            cnt_inc_s = bit_cnt_r + CNT_ONE;
        end else begin
            cnt_inc_s = bit_cnt_r;
        end
        word_s      = {adc_sr_r[SAMPLE_WIDTH-2:0], sdata_sync_r[1]};
        // Data bits sit on counts 1..SAMPLE_WIDTH; count 0 is the I2S one-bit delay slot.
        shift_s     = bclk_rise_s & ~lr_change_s & (cnt_inc_s <= CNT_SW);
        word_done_s = shift_s & (cnt_inc_s == CNT_SW);
        short_s     = lr_change_s & locked_r & enable & (bit_cnt_r < CNT_SW);
        if (!enable) begin
            lock_next_s = 1'b0;
        end else if (left_start_s) begin
            lock_next_s = 1'b1;
        end else begin
            lock_next_s = locked_r;
        end
        // A left start that establishes lock already counts as a locked frame start.
        active_s = enable & (locked_r | left_start_s);
    end

    // Lock state: acquired at a left-channel start while enabled, lost as soon as enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_r <= 1'b0;
        end else begin
            locked_r <= lock_next_s;
        end
    end

    // ADC deserialiser: bit counter, shift register and per-channel holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_prev_r    <= 1'b0;
            bit_cnt_r    <= CNT_ZERO;
            adc_sr_r     <= WORD_ZERO;
            adc_hold_l_r <= WORD_ZERO;
            adc_hold_r_r <= WORD_ZERO;
        end else if (bclk_rise_s) begin
            lr_prev_r <= lrclk_sync_r[1];
            if (lr_change_s) begin
                bit_cnt_r <= CNT_ZERO;
            end else begin
                bit_cnt_r <= cnt_inc_s;
            end
            if (shift_s) begin
                adc_sr_r <= word_s;
            end else begin
                adc_sr_r <= adc_sr_r;
            end
            if (word_done_s && !lrclk_sync_r[1]) begin
                adc_hold_l_r <= word_s;
            end else if (word_done_s) begin
                adc_hold_r_r <= word_s;
            end else begin
                adc_hold_l_r <= adc_hold_l_r;
            end
        end else begin
            lr_prev_r <= lr_prev_r;
        end
    end

    // Frame completeness: a right word is only published if this frame's left word completed under lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_ok_r  <= 1'b0;
            adc_pend_r <= 1'b0;
        end else begin
            if (!enable || left_start_s) begin
                left_ok_r <= 1'b0;
            end else if (word_done_s && !lrclk_sync_r[1]) begin
                left_ok_r <= locked_r;
            end else begin
                left_ok_r <= left_ok_r;
            end
            adc_pend_r <= word_done_s & lrclk_sync_r[1] & locked_r & enable & left_ok_r;
        end
    end

    // Publish the completed sample pair one clk after the right word finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_left  <= WORD_ZERO;
            adc_right <= WORD_ZERO;
            adc_valid <= 1'b0;
        end else if (adc_pend_r && enable) begin
            adc_left  <= adc_hold_l_r;
            adc_right <= adc_hold_r_r;
            adc_valid <= 1'b1;
        end else begin
            adc_valid <= 1'b0;
        end
    end

    // Sticky error for a channel that ended before all data bits arrived.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (short_s) begin
            frame_err <= 1'b1;
        end else begin
            frame_err <= frame_err;
        end
    end

    // DAC serialiser: latch the pair at frame start, reload per channel, shift out on BCLK falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_hold_r_r <= WORD_ZERO;
            dac_sr_r     <= WORD_ZERO;
            ac_dac_sdata <= 1'b0;
            dac_ready    <= 1'b0;
        end else if (!enable) begin
            dac_sr_r     <= WORD_ZERO;
            ac_dac_sdata <= 1'b0;
            dac_ready    <= 1'b0;
        end else begin
            dac_ready <= active_s & left_start_s;
            if (active_s && left_start_s) begin
                dac_hold_r_r <= dac_right;
                dac_sr_r     <= dac_left;
            end else if (active_s && right_start_s) begin
                dac_sr_r <= dac_hold_r_r;
            end else if (bclk_fall_s) begin
                ac_dac_sdata <= dac_sr_r[SAMPLE_WIDTH-1];
                dac_sr_r     <= {dac_sr_r[SAMPLE_WIDTH-2:0], 1'b0};
            end else begin
                dac_sr_r <= dac_sr_r;
            end
        end
    end

endmodule

// File: tb/tb_adau1761_i2s_port.sv
// Directed bench for adau1761_i2s_port: a behavioural codec drives I2S frames
// (16 clk per BCLK period) and captures the DAC stream on each rising BCLK.
module tb_adau1761_i2s_port;

    localparam int SW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          ac_bclk;
    logic          ac_lrclk;
    logic          ac_adc_sdata;
    logic          ac_dac_sdata;
    logic [SW-1:0] adc_left;
    logic [SW-1:0] adc_right;
    logic          adc_valid;
    logic [SW-1:0] dac_left;
    logic [SW-1:0] dac_right;
    logic          dac_ready;
    logic          frame_err;

    always #5 clk = ~clk;

    adau1761_i2s_port #(.SAMPLE_WIDTH(SW), .CNT_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .ac_bclk(ac_bclk), .ac_lrclk(ac_lrclk), .ac_adc_sdata(ac_adc_sdata),
        .ac_dac_sdata(ac_dac_sdata),
        .adc_left(adc_left), .adc_right(adc_right), .adc_valid(adc_valid),
        .dac_left(dac_left), .dac_right(dac_right), .dac_ready(dac_ready),
        .frame_err(frame_err)
    );

    // Pulse monitor: counts output strobes and records the sample pair at each adc_valid.
    int            valid_cnt = 0;
    int            ready_cnt = 0;
    logic [SW-1:0] last_l = '0;
    logic [SW-1:0] last_r = '0;
    always @(negedge clk) begin
        if (adc_valid) begin
            valid_cnt <= valid_cnt + 1;
            last_l    <= adc_left;
            last_r    <= adc_right;
        end
        if (dac_ready) ready_cnt <= ready_cnt + 1;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    logic [SW-1:0] cap_l;
    logic [SW-1:0] cap_r;
    logic          tail_bad;

    // One I2S frame. act_kind: 0 none, 1 drop enable, 2 raise enable, 3 reset pulse,
    // applied in the low half of BCLK bit act_bit of channel act_ch.
    task automatic run_frame(input logic [SW-1:0] l, input logic [SW-1:0] r,
                             input int llen, input int rlen,
                             input int act_ch, input int act_bit, input int act_kind);
        logic [SW-1:0] w;
        logic [SW-1:0] cap;
        int            len;
        tail_bad = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            w   = (ch == 0) ? l : r;
            len = (ch == 0) ? llen : rlen;
            cap = '0;
            for (int i = 0; i < len; i++) begin
                ac_bclk      = 1'b0;
                ac_lrclk     = (ch == 1);
                ac_adc_sdata = (i >= 1 && i <= SW) ? w[SW-i] : 1'b0;
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    if (ch == act_ch && i == act_bit && c == 5) begin
                        if (act_kind == 1) begin
                            check("dac_bit_before_drop", 32'(ac_dac_sdata), 32'd1);
                            enable = 1'b0;
                        end else if (act_kind == 2) begin
                            enable = 1'b1;
                        end else if (act_kind == 3) begin
                            check("dac_bit_before_rst", 32'(ac_dac_sdata), 32'd1);
                            rst = 1'b1;
                        end
                    end
                    if (ch == act_ch && i == act_bit && c == 6) begin
                        if (act_kind == 1) begin
                            check("dac_zero_after_drop", 32'(ac_dac_sdata), 32'd0);
                        end else if (act_kind == 3) begin
                            check("rst_adc_left", 32'(adc_left), 32'd0);
                            check("rst_adc_right", 32'(adc_right), 32'd0);
                            check("rst_dac_sdata", 32'(ac_dac_sdata), 32'd0);
                            check("rst_frame_err", 32'(frame_err), 32'd0);
                            check("rst_valid_ready", 32'({adc_valid, dac_ready}), 32'd0);
                            rst = 1'b0;
                        end
                    end
                end
                ac_bclk = 1'b1;
                if (i >= 1 && i <= SW) cap = {cap[SW-2:0], ac_dac_sdata};
                else if (i > SW && ac_dac_sdata) tail_bad = 1'b1;
                repeat (8) @(negedge clk);
            end
            if (ch == 0) cap_l = cap;
            else cap_r = cap;
        end
    endtask

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic [SW-1:0] dl;
        logic [SW-1:0] dr;
    } vec_t;

    vec_t vecs[3];
    int   v0;
    int   r0;

    // Run a full frame and check everything a clean locked frame must produce.
    task automatic good_frame(input vec_t v, input logic err_exp);
        dac_left  = v.dl;
        dac_right = v.dr;
        v0 = valid_cnt;
        r0 = ready_cnt;
        run_frame(v.l, v.r, 32, 32, -1, -1, 0);
        check("valid_once", 32'(valid_cnt - v0), 32'd1);
        check("ready_once", 32'(ready_cnt - r0), 32'd1);
        check("adc_left", 32'(last_l), 32'(v.l));
        check("adc_right", 32'(last_r), 32'(v.r));
        check("dac_cap_left", 32'(cap_l), 32'(v.dl));
        check("dac_cap_right", 32'(cap_r), 32'(v.dr));
        check("dac_tail_zero", 32'(tail_bad), 32'd0);
        check("frame_err", 32'(frame_err), 32'(err_exp));
    endtask

    initial begin
        vecs[0] = '{l: 24'hABCDEF, r: 24'h123456, dl: 24'h800001, dr: 24'h7FFFFF};
        vecs[1] = '{l: 24'h000001, r: 24'hFFFFFF, dl: 24'h000000, dr: 24'h800000};
        vecs[2] = '{l: 24'h5A5A5A, r: 24'hA5A5A5, dl: 24'h123456, dr: 24'hFEDCBA};

        rst = 1'b1; enable = 1'b0;
        ac_bclk = 1'b0; ac_lrclk = 1'b0; ac_adc_sdata = 1'b0;
        dac_left = 24'h0; dac_right = 24'h0;
        repeat (5) @(negedge clk);
        check("reset_adc_left", 32'(adc_left), 32'd0);
        check("reset_adc_right", 32'(adc_right), 32'd0);
        check("reset_valid", 32'(adc_valid), 32'd0);
        check("reset_ready", 32'(dac_ready), 32'd0);
        check("reset_dac_sdata", 32'(ac_dac_sdata), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);

        // Preamble: LRCLK idles low, so no 1->0 edge and no lock in this frame.
        v0 = valid_cnt; r0 = ready_cnt;
        run_frame(24'hABCDEF, 24'h123456, 32, 32, -1, -1, 0);
        check("preamble_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("preamble_no_ready", 32'(ready_cnt - r0), 32'd0);

        for (int k = 0; k < 3; k++) good_frame(vecs[k], 1'b0);

        // Short right channel: no valid this frame, error flagged at next left start.
        dac_left = 24'hFFFFFF;
        v0 = valid_cnt;
        run_frame(24'h111111, 24'h222222, 32, 16, -1, -1, 0);
        check("short_no_valid", 32'(valid_cnt - v0), 32'd0);
        good_frame('{l: 24'h333333, r: 24'h444444, dl: 24'h0F0F0F, dr: 24'h00FF00}, 1'b1);

        // Enable dropped mid left word.
        dac_left = 24'hFFFFFF;
        v0 = valid_cnt;
        run_frame(24'h555555, 24'h666666, 32, 32, 0, 8, 1);
        check("drop_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("drop_err_sticky", 32'(frame_err), 32'd1);

        // Enable raised mid right channel: nothing until next left start.
        v0 = valid_cnt; r0 = ready_cnt;
        run_frame(24'h777777, 24'h888888, 32, 32, 1, 10, 2);
        check("reen_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("reen_no_ready", 32'(ready_cnt - r0), 32'd0);
        good_frame('{l: 24'h0F0F0F, r: 24'hF0F0F0, dl: 24'hC00003, dr: 24'h300000}, 1'b1);

        // Reset pulse mid left channel.
        dac_left = 24'hFFFFFF;
        v0 = valid_cnt;
        run_frame(24'h999999, 24'hAAAAAA, 32, 32, 0, 8, 3);
        check("rst_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("rst_adc_left_held", 32'(adc_left), 32'd0);
        good_frame('{l: 24'hFEDCBA, r: 24'h13579B, dl: 24'hA5A5A5, dr: 24'h000001}, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
